// File: rtl/line_buffer3.sv
// Two-line buffer feeding the 3x3 convolution stage: emits {top,mid,bot} columns for rows y-2, y-1, y.
// Latency: one cycle from an accepted pixel to its column on the outputs (shift_en pulses with it).
// Backpressure: no internal buffering; in_ready mirrors out_ready and outputs hold while stalled.
// Optional: define LB_REPLICATE_BORDER_EN to replicate the top border so rows 0-1 produce valid windows.
module line_buffer3 #(
    parameter int MAX_WIDTH = 1024,
    parameter int COLW      = 10,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [COLW-1:0]   line_width,
    input  logic              sof,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              out_ready,
    output logic [DATA_W-1:0] top_pix,
    output logic [DATA_W-1:0] mid_pix,
    output logic [DATA_W-1:0] bot_pix,
    output logic              shift_en,
    output logic              win_valid,
    output logic [COLW-1:0]   col_idx
);

    // MAX_WIDTH truncates to 0 when it equals 2^COLW; width-1 then wraps to the last column.
    localparam logic [COLW-1:0] WIDTH_RST = COLW'(MAX_WIDTH);

    // Line memories: L0 holds row y-1, L1 holds row y-2.
    logic [DATA_W-1:0] r_l0 [MAX_WIDTH];
    logic [DATA_W-1:0] r_l1 [MAX_WIDTH];

    logic [COLW-1:0]   r_col;
    logic [1:0]        r_row;
    logic [COLW-1:0]   r_width;

    logic              w_accept;
    logic [COLW-1:0]   w_c;
    logic [1:0]        w_row_beat;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_top_nxt;
    logic [DATA_W-1:0] w_mid_nxt;
    logic              w_win_nxt;

    assign in_ready   = out_ready;
    assign w_accept   = in_valid && out_ready;
    // A sof beat always lands in column 0 of row 0, whatever the counters say.
    assign w_c        = sof ? '0 : r_col;
    assign w_row_beat = sof ? 2'd0 : r_row;
    assign w_rd0      = r_l0[w_c];
    assign w_rd1      = r_l1[w_c];

    // Choose the column contents and window-valid flag for the beat being accepted.
    always_comb begin
        w_top_nxt = w_rd1;
        w_mid_nxt = w_rd0;
        w_win_nxt = (w_row_beat == 2'd2);
`ifdef LB_REPLICATE_BORDER_EN
        // Missing rows above the image are replaced by the nearest real row.
        w_win_nxt = 1'b1;
        if (w_row_beat == 2'd0) begin
            w_top_nxt = in_data;
            w_mid_nxt = in_data;
        end else if (w_row_beat == 2'd1) begin
            w_top_nxt = w_rd0;
            w_mid_nxt = w_rd0;
        end
`endif
    end

    // Read-first line memories: the old y-1 pixel moves down to y-2, the new pixel becomes y-1.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_l1[w_c] <= w_rd0;
            r_l0[w_c] <= in_data;
        end
    end

    // Column/row counters; sof restarts the frame at any point, row saturates at 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col   <= '0;
            r_row   <= 2'd0;
            r_width <= WIDTH_RST;
        end else if (w_accept) begin
            if (sof) begin
                r_width <= line_width;
                if (line_width == COLW'(1)) begin
                    r_col <= '0;
                    r_row <= 2'd1;
                end else begin
                    r_col <= COLW'(1);
                    r_row <= 2'd0;
                end
            end else if (r_col == r_width - COLW'(1)) begin
                r_col <= '0;
                if (r_row != 2'd2) begin
                    r_row <= r_row + 2'd1;
                end
            end else begin
                r_col <= r_col + COLW'(1);
            end
        end
    end

    // Output column registers: load on accept, otherwise hold with shift_en low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_pix   <= '0;
            mid_pix   <= '0;
            bot_pix   <= '0;
            shift_en  <= 1'b0;
            win_valid <= 1'b0;
            col_idx   <= '0;
        end else if (w_accept) begin
            top_pix   <= w_top_nxt;
            mid_pix   <= w_mid_nxt;
            bot_pix   <= in_data;
            shift_en  <= 1'b1;
            win_valid <= w_win_nxt;
            col_idx   <= w_c;
        end else begin
            shift_en  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer3.sv
// Self-checking bench for line_buffer3: directed frames plus random frames against an image-array model.
// Model indexes a full-height image by true row/column, so top/mid are simply img[r-2][c] and img[r-1][c].
// Backpressure is exercised with random and patterned out_ready.
module tb_line_buffer3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  line_width;
    logic        sof;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_ready;
    logic [31:0] top_pix;
    logic [31:0] mid_pix;
    logic [31:0] bot_pix;
    logic        shift_en;
    logic        win_valid;
    logic [9:0]  col_idx;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] img [0:31][0:15];
    int          m_row, m_col, m_width;
    logic [31:0] exp_top, exp_mid, exp_bot;
    logic        exp_shift, exp_win;
    int          exp_col;
    bit          tm_known;

    line_buffer3 dut (
        .clk(clk), .rst_n(rst_n), .line_width(line_width), .sof(sof),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_ready(out_ready), .top_pix(top_pix), .mid_pix(mid_pix),
        .bot_pix(bot_pix), .shift_en(shift_en), .win_valid(win_valid),
        .col_idx(col_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_width = 1024;
        exp_top = '0; exp_mid = '0; exp_bot = '0;
        exp_shift = 1'b0; exp_win = 1'b0; exp_col = 0; tm_known = 1'b1;
    endtask

    task automatic model_accept(input logic s, input logic [31:0] d);
        int rb, c;
        if (s) begin
            m_row = 0; m_col = 0;
            m_width = (line_width == 10'd0) ? 1024 : int'(line_width);
        end
        rb = m_row; c = m_col;
        if (rb < 32 && c < 16) img[rb][c] = d;
        exp_bot = d; exp_col = c; exp_shift = 1'b1;
`ifdef LB_REPLICATE_BORDER_EN
        exp_win = 1'b1; tm_known = 1'b1;
        if (rb == 0) begin
            exp_top = d; exp_mid = d;
        end else if (rb == 1) begin
            exp_top = img[0][c]; exp_mid = img[0][c];
        end else begin
            exp_top = img[rb-2][c]; exp_mid = img[rb-1][c];
        end
`else
        exp_win = (rb >= 2); tm_known = (rb >= 2);
        if (tm_known) begin
            exp_top = img[rb-2][c]; exp_mid = img[rb-1][c];
        end
`endif
        m_col++;
        if (m_col == m_width) begin
            m_col = 0; m_row++;
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [31:0] d, input logic ordy);
        in_valid = v; sof = s; in_data = d; out_ready = ordy;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, ordy});
        @(posedge clk);
        #1;
        if (v && ordy) model_accept(s, d);
        else exp_shift = 1'b0;
        chk("shift_en", {31'd0, shift_en}, {31'd0, exp_shift});
        chk("col_idx", {22'd0, col_idx}, exp_col);
        chk("win_valid", {31'd0, win_valid}, {31'd0, exp_win});
        chk("bot_pix", bot_pix, exp_bot);
        if (tm_known) begin
            chk("top_pix", top_pix, exp_top);
            chk("mid_pix", mid_pix, exp_mid);
        end
    endtask

    initial begin
        int pulses, idx, k, first_win, w, rows, n;
        logic [31:0] d;
        logic v, r;
        logic [3:0] pat;

        // ---- Reset with random inputs ----
        rst_n = 1'b0; line_width = 10'd4;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom); sof = 1'($urandom); in_data = $urandom;
            out_ready = 1'($urandom);
            #1;
            chk("rst_in_ready", {31'd0, in_ready}, {31'd0, out_ready});
            chk("rst_top", top_pix, 32'd0);
            chk("rst_mid", mid_pix, 32'd0);
            chk("rst_bot", bot_pix, 32'd0);
            chk("rst_shift", {31'd0, shift_en}, 32'd0);
            chk("rst_win", {31'd0, win_valid}, 32'd0);
            chk("rst_col", {22'd0, col_idx}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; sof = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Width 4, 3 rows, out_ready = 1 ----
        line_width = 10'd4;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i == 0, 32'(16 * (i / 4) + (i % 4)), 1'b1);
            if (shift_en === 1'b1) pulses++;
`ifdef LB_REPLICATE_BORDER_EN
            if (i == 0) begin
                chk("rep_r0c0_top", top_pix, 32'h00);
                chk("rep_r0c0_mid", mid_pix, 32'h00);
                chk("rep_r0c0_win", {31'd0, win_valid}, 32'd1);
            end
            if (i == 6) begin
                chk("rep_r1c2_top", top_pix, 32'h02);
                chk("rep_r1c2_mid", mid_pix, 32'h02);
                chk("rep_r1c2_bot", bot_pix, 32'h12);
            end
`endif
        end
        chk("r2c3_top", top_pix, 32'h03);
        chk("r2c3_mid", mid_pix, 32'h13);
        chk("r2c3_bot", bot_pix, 32'h23);
        chk("r2c3_win", {31'd0, win_valid}, 32'd1);
        chk("r2c3_col", {22'd0, col_idx}, 32'd3);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        if (shift_en === 1'b1) pulses++;
        chk("shift_pulse_count", 32'(pulses), 32'd12);

        // ---- Same frame, out_ready pattern 1,0,0,1 ----
        pat = 4'b1001;
        idx = 0; k = 0;
        while (idx < 12 && k < 100) begin
            r = pat[3 - (k % 4)];
            step(1'b1, idx == 0, 32'(16 * (idx / 4) + (idx % 4)), r);
            if (r) idx++;
            k++;
        end
        chk("stall_frame_beats", 32'(idx), 32'd12);

        // ---- sof abort at row 1 col 2 ----
        for (int i = 0; i < 6; i++) step(1'b1, i == 0, 32'(16 * (i / 4) + (i % 4)), 1'b1);
        step(1'b1, 1'b1, 32'hAA, 1'b1);
        chk("abort_col", {22'd0, col_idx}, 32'd0);
`ifndef LB_REPLICATE_BORDER_EN
        chk("abort_win", {31'd0, win_valid}, 32'd0);
`endif
        first_win = (win_valid === 1'b1) ? 1 : 0;
        for (int i = 2; i <= 10; i++) begin
            step(1'b1, 1'b0, $urandom, 1'b1);
            if (first_win == 0 && win_valid === 1'b1) first_win = i;
        end
`ifdef LB_REPLICATE_BORDER_EN
        chk("abort_first_win", 32'(first_win), 32'd1);
`else
        chk("abort_first_win", 32'(first_win), 32'd9);
`endif

        // ---- Width 1, values 1..4 ----
        line_width = 10'd1;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, i == 1, 32'(i), 1'b1);
            if (i == 3) begin
                chk("w1_3_top", top_pix, 32'd1);
                chk("w1_3_mid", mid_pix, 32'd2);
                chk("w1_3_bot", bot_pix, 32'd3);
                chk("w1_3_win", {31'd0, win_valid}, 32'd1);
            end
        end
        chk("w1_4_top", top_pix, 32'd2);
        chk("w1_4_mid", mid_pix, 32'd3);
        chk("w1_4_bot", bot_pix, 32'd4);

        // ---- Random frames with random valid/ready ----
        for (int f = 0; f < 4; f++) begin
            w = $urandom_range(1, 8);
            rows = $urandom_range(3, 5);
            line_width = 10'(w);
            n = 0; k = 0;
            while (n < w * rows && k < 2000) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) != 0);
                d = $urandom;
                step(v, n == 0, d, r);
                if (v && r) n++;
                k++;
            end
            chk("rand_frame_beats", 32'(n), 32'(w * rows));
        end

        // ---- Reset asserted mid-frame ----
        line_width = 10'd5;
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, $urandom, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_top", top_pix, 32'd0);
        chk("midrst_bot", bot_pix, 32'd0);
        chk("midrst_col", {22'd0, col_idx}, 32'd0);
        chk("midrst_win", {31'd0, win_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        line_width = 10'd3;
        for (int i = 0; i < 9; i++) step(1'b1, i == 0, $urandom, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
